// File: rtl/fp_addsub_pipe.sv
// Floating-point add/subtract with explicit-leading-one fraction and truncating alignment/normalisation.
// Latency: 3 register stages (align, add/sub, normalise/pack), one op per cycle.
// Backpressure: per-stage valid; a stage advances when empty or its successor advances; bubbles collapse.
module fp_addsub_pipe #(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 16,
    parameter int TAG_W  = 4,
    localparam int W     = 1 + EXP_W + FRAC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [W-1:0]     i_a,
    input  logic [W-1:0]     i_b,
    input  logic             i_adsb,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [W-1:0]     o_c,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam int LZW = $clog2(FRAC_W + 1);
    localparam int XW  = EXP_W + LZW + 1;
    localparam logic [EXP_W:0]   SHIFT_LIM = (EXP_W + 1)'(FRAC_W);
    localparam logic [EXP_W-1:0] EXP_MAX   = '1;

    logic ready_en;
    logic s1_vld, s2_vld, s3_vld;
    logic s1_adv, s2_adv, s3_adv;
    logic in_fire;

    assign s3_adv  = !s3_vld || i_ready;
    assign s2_adv  = !s2_vld || s3_adv;
    assign s1_adv  = !s1_vld || s2_adv;
    // ready_en keeps o_ready low during reset and until the first clock edge after release
    assign o_ready = ready_en && s1_adv;
    assign in_fire = i_valid && o_ready;
    assign o_valid = s3_vld;

    // ---------------- S1: compare, select, align ----------------
    logic               a_s, b_s, b_s_eff;
    logic [EXP_W-1:0]   a_e, b_e;
    logic [FRAC_W-1:0]  a_f, b_f;
    logic               a_zero, b_zero, a_big;
    logic               big_s;
    logic [EXP_W-1:0]   big_e, sml_e, exp_diff;
    logic [FRAC_W-1:0]  big_f, sml_f, sml_sh;

    assign {a_s, a_e, a_f} = i_a;
    assign {b_s, b_e, b_f} = i_b;
    assign b_s_eff = b_s ^ i_adsb;
    assign a_zero  = (a_f == '0);
    assign b_zero  = (b_f == '0);

    always_comb begin
        // a zero-fraction operand never wins the compare, whatever its exponent
        if (b_zero)
            a_big = 1'b1;
        else if (a_zero)
            a_big = 1'b0;
        else if (a_e != b_e)
            a_big = (a_e > b_e);
        else
            a_big = (a_f >= b_f);
    end

    always_comb begin
        big_s = a_big ? a_s : b_s_eff;
        big_e = a_big ? a_e : b_e;
        big_f = a_big ? a_f : b_f;
        sml_e = a_big ? b_e : a_e;
        sml_f = a_big ? b_f : a_f;
        exp_diff = big_e - sml_e;
        if ({1'b0, exp_diff} >= SHIFT_LIM)
            sml_sh = '0;
        else
            sml_sh = sml_f >> exp_diff;
    end

    logic               s1_sign, s1_sub;
    logic [EXP_W-1:0]   s1_exp;
    logic [FRAC_W-1:0]  s1_big, s1_sml;
    logic [TAG_W-1:0]   s1_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
            s1_vld   <= 1'b0;
            s1_sign  <= 1'b0;
            s1_sub   <= 1'b0;
            s1_exp   <= '0;
            s1_big   <= '0;
            s1_sml   <= '0;
            s1_tag   <= '0;
        end else begin
            ready_en <= 1'b1;
            if (s1_adv) begin
                s1_vld  <= in_fire;
                s1_sign <= big_s;
                s1_sub  <= a_s ^ b_s_eff;
                s1_exp  <= big_e;
                s1_big  <= big_f;
                s1_sml  <= sml_sh;
                s1_tag  <= i_tag;
            end
        end
    end

    // ---------------- S2: add / subtract ----------------
    logic [FRAC_W:0] add_w, sub_w, sum_nxt;
    logic            sign_nxt;

    assign add_w = {1'b0, s1_big} + {1'b0, s1_sml};
    assign sub_w = {1'b0, s1_big} - {1'b0, s1_sml};

    always_comb begin
        sum_nxt  = add_w;
        sign_nxt = s1_sign;
        if (s1_sub) begin
            // an unnormalised larger operand can still lose after alignment; take magnitude, flip sign
            if (sub_w[FRAC_W]) begin
                sum_nxt  = -sub_w;
                sign_nxt = !s1_sign;
            end else begin
                sum_nxt  = sub_w;
            end
        end
    end

    logic               s2_sign;
    logic [EXP_W-1:0]   s2_exp;
    logic [FRAC_W:0]    s2_sum;
    logic [TAG_W-1:0]   s2_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld  <= 1'b0;
            s2_sign <= 1'b0;
            s2_exp  <= '0;
            s2_sum  <= '0;
            s2_tag  <= '0;
        end else if (s2_adv) begin
            s2_vld  <= s1_vld;
            s2_sign <= sign_nxt;
            s2_exp  <= s1_exp;
            s2_sum  <= sum_nxt;
            s2_tag  <= s1_tag;
        end
    end

    // ---------------- S3: normalise, pack ----------------
    function automatic logic [LZW-1:0] lzc(input logic [FRAC_W-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(FRAC_W);
        for (int i = 0; i < FRAC_W; i++) begin
            if (v[i])
                n = LZW'(FRAC_W - 1 - i);
        end
        return n;
    endfunction

    logic [LZW-1:0] n_lz;
    logic [W-1:0]   r_c;
    logic           r_ovf, r_zero;

    assign n_lz = lzc(s2_sum[FRAC_W-1:0]);

    always_comb begin
        r_c    = '0;
        r_ovf  = 1'b0;
        r_zero = 1'b0;
        if (s2_sum[FRAC_W]) begin
            if (s2_exp == EXP_MAX) begin
                r_c   = {s2_sign, EXP_MAX, {FRAC_W{1'b1}}};
                r_ovf = 1'b1;
            end else begin
                r_c   = {s2_sign, s2_exp + 1'b1, s2_sum[FRAC_W:1]};
            end
        end else if (s2_sum[FRAC_W-1:0] == '0 || XW'(n_lz) > XW'(s2_exp)) begin
            r_zero = 1'b1;
        end else begin
            r_c = {s2_sign, s2_exp - EXP_W'(n_lz), s2_sum[FRAC_W-1:0] << n_lz};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_vld <= 1'b0;
            o_c    <= '0;
            o_tag  <= '0;
            o_ovf  <= 1'b0;
            o_zero <= 1'b0;
        end else if (s3_adv) begin
            s3_vld <= s2_vld;
            o_c    <= r_c;
            o_tag  <= s2_tag;
            o_ovf  <= r_ovf;
            o_zero <= r_zero;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: directed literal vectors, backpressure, mid-stream reset and a long random run
// checked against an integer-arithmetic reference model through an in-order scoreboard.
module tb_fp_addsub_pipe;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 16;
    localparam int TAG_W  = 4;
    localparam int W      = 1 + EXP_W + FRAC_W;
    localparam int VW     = W + 2 + TAG_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_valid, o_ready, i_adsb, o_valid, i_ready, o_ovf, o_zero;
    logic [W-1:0]     i_a, i_b, o_c;
    logic [TAG_W-1:0] i_tag, o_tag;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [VW-1:0] exp_q[$];
    bit          rand_rdy = 1'b0;

    always #5 clk = ~clk;

    fp_addsub_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_adsb(i_adsb), .i_tag(i_tag),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_c(o_c), .o_tag(o_tag), .o_ovf(o_ovf), .o_zero(o_zero)
    );

    // Reference: signed integer sum of the two magnitudes at the larger exponent, then renormalise.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        int     ea, eb, fa, fb, e, d, ebig, esml, fbig, fsml;
        bit     sa, sb, abig, sbig, ssml, s;
        longint v, m;
        logic [EXP_W-1:0]  eo;
        logic [FRAC_W-1:0] fo;
        sa = a[W-1];
        sb = b[W-1] ^ sub;
        ea = int'(a[W-2:FRAC_W]);
        eb = int'(b[W-2:FRAC_W]);
        fa = int'(a[FRAC_W-1:0]);
        fb = int'(b[FRAC_W-1:0]);
        if (fb == 0)       abig = 1'b1;
        else if (fa == 0)  abig = 1'b0;
        else if (ea != eb) abig = (ea > eb);
        else               abig = (fa >= fb);
        sbig = abig ? sa : sb;  ssml = abig ? sb : sa;
        ebig = abig ? ea : eb;  esml = abig ? eb : ea;
        fbig = abig ? fa : fb;  fsml = abig ? fb : fa;
        d = ebig - esml;
        if (d < 0 || d >= FRAC_W) fsml = 0;
        else                      fsml = fsml >> d;
        v = (sbig ? -longint'(fbig) : longint'(fbig)) + (ssml ? -longint'(fsml) : longint'(fsml));
        if (v == 0) return {{W{1'b0}}, 2'b01};
        s = (v < 0);
        m = s ? -v : v;
        e = ebig;
        if (m >= (longint'(1) << FRAC_W)) begin
            m = m >> 1;
            e = e + 1;
            if (e > (1 << EXP_W) - 1) return {s, {EXP_W{1'b1}}, {FRAC_W{1'b1}}, 2'b10};
        end
        while (m < (longint'(1) << (FRAC_W - 1))) begin
            if (e == 0) return {{W{1'b0}}, 2'b01};
            m = m << 1;
            e = e - 1;
        end
        eo = e[EXP_W-1:0];
        fo = m[FRAC_W-1:0];
        return {s, eo, fo, 2'b00};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
        end
    endtask

    // Single compare process: scoreboard on every transfer, hold-stability while stalled.
    task automatic monitor();
        logic [VW-1:0] held;
        logic [VW-1:0] e;
        bit hold_vld;
        hold_vld = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                hold_vld = 1'b0;
            end else begin
                if (hold_vld)
                    check("hold_stable", 64'({o_valid, o_c, o_ovf, o_zero, o_tag}), 64'({1'b1, held}));
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", 64'(o_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", 64'({o_c, o_ovf, o_zero, o_tag}), 64'(e));
                    end
                end
                hold_vld = o_valid && !i_ready;
                held = {o_c, o_ovf, o_zero, o_tag};
                if (i_valid && o_ready)
                    exp_q.push_back({model(i_a, i_b, i_adsb), i_tag});
            end
        end
    endtask

    task automatic rdy_toggler();
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) i_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the accepting posedge with i_valid dropped.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic [TAG_W-1:0] t);
        int n;
        i_valid = 1'b1; i_a = a; i_b = b; i_adsb = s; i_tag = t;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_ready && n < 200);
        if (!o_ready) check("accept_timeout", 64'(o_ready), 64'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic run_vec(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input logic [W+1:0] want);
        int n;
        check({"model_", nm}, 64'(model(a, b, s)), 64'(want));
        send(a, b, s, 4'hA);
        n = 1;
        while (!o_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({"latency_", nm}, 64'(n), 64'd3);
        check(nm, 64'({o_c, o_ovf, o_zero}), 64'(want));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] r;
        int sel;
        r = W'($urandom);
        sel = $urandom_range(0, 9);
        r[FRAC_W-1] = 1'b1;
        if (sel == 0) r[FRAC_W-1:0] = '0;
        if (sel == 1) r[W-2:FRAC_W] = '1;
        if (sel == 2) r[W-2:FRAC_W] = EXP_W'($urandom_range(0, 2));
        if (sel >= 3 && sel <= 5) r[W-2:FRAC_W] = EXP_W'($urandom_range(14, 18));
        return r;
    endfunction

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_a = '0; i_b = '0; i_adsb = 1'b0; i_tag = '0;
        fork
            monitor();
            rdy_toggler();
        join_none

        #2;
        check("reset_outputs", 64'({o_valid, o_ready, o_c, o_tag, o_ovf, o_zero}), 64'd0);
        #20 rst_n = 1'b1;
        #1;
        check("ready_before_first_edge", 64'(o_ready), 64'd0);
        @(posedge clk);
        #1;
        check("ready_after_first_edge", 64'(o_ready), 64'd1);

        run_vec("add_equal",      22'h108000, 22'h108000, 1'b0, {22'h118000, 2'b00});
        run_vec("add_shifted",    22'h108000, 22'h0F8000, 1'b0, {22'h10C000, 2'b00});
        run_vec("sub_shifted",    22'h108000, 22'h0F8000, 1'b1, {22'h0F8000, 2'b00});
        run_vec("cancel",         22'h108000, 22'h108000, 1'b1, {22'h000000, 2'b01});
        run_vec("overflow",       22'h1F8000, 22'h1F8000, 1'b0, {22'h1FFFFF, 2'b10});
        run_vec("zero_big_exp",   22'h1F0000, 22'h0A8000, 1'b0, {22'h0A8000, 2'b00});
        run_vec("neg_result",     22'h018000, 22'h01C000, 1'b1, {22'h208000, 2'b00});
        run_vec("neg_add",        22'h308000, 22'h0F8000, 1'b0, {22'h2F8000, 2'b00});
        run_vec("underflow",      22'h00C000, 22'h00A000, 1'b1, {22'h000000, 2'b01});

        // Stall the output: three ops fill the pipe, the fourth is refused.
        i_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            i_valid = 1'b1; i_a = 22'h108000; i_b = 22'h0F8000; i_adsb = 1'b0; i_tag = TAG_W'(k);
            @(negedge clk);
            check($sformatf("bp_ready_%0d", k), 64'(o_ready), (k <= 3) ? 64'd1 : 64'd0);
            if (k <= 3) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("bp_drain_%0d", k), 64'({o_valid, o_tag}), 64'({1'b1, TAG_W'(k)}));
            if (k == 1) begin
                @(posedge clk);
                #1;
                i_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;

        // Reset with three ops in flight.
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(22'h108000, 22'h108000, 1'b0, TAG_W'(k + 5));
        #2 rst_n = 1'b0;
        #1;
        check("midreset_outputs", 64'({o_valid, o_ready, o_c, o_tag, o_ovf, o_zero}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        i_ready = 1'b1;
        #1;
        check("midreset_ready_before_edge", 64'(o_ready), 64'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) check("midreset_ready_after_edge", 64'(o_ready), 64'd1);
            check("no_stale_valid", 64'(o_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Random traffic with random downstream stalls.
        rand_rdy = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            logic [W-1:0] a, b;
            int idle;
            idle = $urandom_range(0, 3);
            if (idle > 1) begin
                repeat (idle - 1) begin
                    @(posedge clk);
                    #1;
                end
            end
            a = rand_op();
            b = ($urandom_range(0, 7) == 0) ? a : rand_op();
            send(a, b, 1'($urandom_range(0, 1)), TAG_W'(n));
        end
        rand_rdy = 1'b0;
        i_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 50) begin
                @(posedge clk);
                n++;
            end
        end
        @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_addsub_pipe.md
FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent width.
REQ-002 SHALL have parameter FRAC_W, default 16, fraction width; explicit leading one at MSB, no hidden bit.
REQ-003 SHALL have parameter TAG_W, default 4, sideband tag width; W = 1+EXP_W+FRAC_W, packed {sign, exp, frac}.
REQ-004 SHALL have port clk  in  1  single clock; all state on posedge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_valid  in  1  operand valid.
REQ-007 SHALL have port o_ready  out  1  block can accept an operand this cycle.
REQ-008 SHALL have port i_a  in  W  operand A.
REQ-009 SHALL have port i_b  in  W  operand B.
REQ-010 SHALL have port i_adsb  in  1  0: A+B, 1: A-B.
REQ-011 SHALL have port i_tag  in  TAG_W  sideband, returned unchanged with result.
REQ-012 SHALL have port o_valid  out  1  result valid.
REQ-013 SHALL have port i_ready  in  1  downstream accepts result.
REQ-014 SHALL have port o_c  out  W  result.
REQ-015 SHALL have port o_tag  out  TAG_W  tag of result.
REQ-016 SHALL have port o_ovf  out  1  exponent overflow, result saturated.
REQ-017 SHALL have port o_zero  out  1  result is zero.

Function
REQ-018 SHALL be a 3-register pipeline: S1 align (compare, select, shift), S2 add/sub (FRAC_W+1 bits incl. carry), S3 normalise/pack; each stage has its own valid bit.
REQ-019 SHALL transfer input when i_valid & o_ready; output when o_valid & i_ready.
REQ-020 SHALL advance stage k when stage k empty or stage k+1 advancing (S3 advances on i_ready or empty); bubbles collapse; o_ready = S1 advancing.
REQ-021 SHALL have latency 3 cycles from input transfer to o_valid with no stall; throughput 1 op/cycle.
REQ-022 SHALL hold o_c, o_tag, o_ovf, o_zero stable while o_valid & !i_ready.
REQ-023 SHALL select larger magnitude: larger exp; equal exp, larger/equal-or-A fraction; smaller fraction right-shifted by exp difference; shift >= FRAC_W gives 0.
REQ-024 SHALL perform effective subtract when sign_a ^ sign_b ^ i_adsb = 1, else add.
REQ-025 SHALL take result sign from larger operand (B sign inverted when i_adsb=1); exact cancellation gives +0.
REQ-026 SHALL normalise on carry: frac >>1, exp+1; else left-shift by leading-zero count, exp-lzc.
REQ-027 SHALL truncate (no rounding) on all right shifts.
REQ-028 SHALL, on exp+1 exceeding 2^EXP_W-1, output sign, exp all ones, frac all ones, o_ovf=1.
REQ-029 SHALL, on zero sum or lzc > exp (underflow), output all zeros, o_zero=1, o_ovf=0.
REQ-030 SHALL treat operand with frac=0 as zero regardless of exponent.

Reset
REQ-031 SHALL, while rst_n=0, clear all stage valids asynchronously: o_valid=0, o_ready=0, o_c=0, o_tag=0, o_ovf=0, o_zero=0.
REQ-032 SHALL discard in-flight operations on reset; o_ready=1 from first posedge after rst_n rises.

Verification
REQ-033 SHALL verify: i_a=0x108000, i_b=0x108000, adsb=0 -> 3 cycles later o_c=0x118000, ovf=0, zero=0.
REQ-034 SHALL verify: i_a=0x108000, i_b=0x0F8000, adsb=0 -> o_c=0x10C000; same with adsb=1 -> o_c=0x0F8000.
REQ-035 SHALL verify: i_a=i_b=0x108000, adsb=1 -> o_c=0x000000, o_zero=1; i_a=i_b=0x1F8000, adsb=0 -> o_c=0x1FFFFF, o_ovf=1.
REQ-036 SHALL verify: i_ready=0, 4 back-to-back ops tags 1..4 -> o_ready low after 3 accepted; i_ready=1 -> tags 1..4 emerge in order, one per cycle, none lost/duplicated.
REQ-037 SHALL verify: random valid/ready toggling, 10k ops vs reference model -> all results and tags match in order.
REQ-038 SHALL verify: rst_n low mid-stream with 3 ops in flight -> o_valid=0 same cycle; after release no stale result appears.
